// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM state
// encodings, the default burst limit and the memory strobe polarity.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam int   BURST_MAX_DEFAULT = 4;
    localparam logic STROBE_ACTIVE     = 1'b0;
    localparam logic STROBE_INACTIVE   = 1'b1;

    // Grant state that belongs to requester k.
    function automatic arb_state_t grant_of(input logic k);
        return k ? GRANT1 : GRANT0;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin pick: a lone requester wins outright; on a tie the
// requester that was not served most recently wins.
module rr_pick (
    input  logic req_0,
    input  logic req_1,
    input  logic last_served,
    output logic winner,
    output logic valid
);

    // Combinational winner selection.
    always_comb begin
        valid = req_0 | req_1;
        if (req_0 && req_1) begin
            winner = ~last_served;
        end else begin
            winner = req_1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter. One access completes per ack
// cycle; the memory strobes, address and write data are driven
// combinationally from the current owner's request. A burst limit forces
// the grant over to a waiting requester without an idle cycle.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_0,
    input  logic       we_0,
    input  logic [7:0] addr_0,
    input  logic [7:0] wdata_0,
    output logic       ack_0,
    output logic [7:0] rdata_0,
    input  logic       req_1,
    input  logic       we_1,
    input  logic [7:0] addr_1,
    input  logic [7:0] wdata_1,
    output logic       ack_1,
    output logic [7:0] rdata_1,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data_out,
    input  logic [7:0] mem_in,
    output logic       R,
    output logic       W,
    output logic       busy,
    output logic       owner
);

    // Count value on which the current ack is the last one of a burst.
    localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

    arb_state_t r_state;
    arb_state_t w_state_next;
    logic [3:0] r_burst_cnt;
    logic [3:0] w_burst_cnt_next;
    logic       r_last_served;
    logic       w_last_served_next;

    logic       w_pick_winner;
    logic       w_pick_valid;
    logic       w_granted;
    logic       w_sel;
    logic       w_sel_req;
    logic       w_other_req;
    logic       w_sel_we;
    logic [7:0] w_sel_addr;
    logic [7:0] w_sel_wdata;
    logic       w_active;

    rr_pick u_rr_pick (
        .req_0       (req_0),
        .req_1       (req_1),
        .last_served (r_last_served),
        .winner      (w_pick_winner),
        .valid       (w_pick_valid)
    );

    // State, burst counter and round-robin history; reset leaves requester 0
    // as the winner of the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_burst_cnt   <= 4'd0;
            r_last_served <= 1'b1;
        end else begin
            r_state       <= w_state_next;
            r_burst_cnt   <= w_burst_cnt_next;
            r_last_served <= w_last_served_next;
        end
    end

    // Route the owning requester's signals; an access happens only while
    // the owner is still requesting.
    always_comb begin
        w_granted   = (r_state == GRANT0) || (r_state == GRANT1);
        w_sel       = (r_state == GRANT1);
        w_sel_req   = w_sel ? req_1   : req_0;
        w_other_req = w_sel ? req_0   : req_1;
        w_sel_we    = w_sel ? we_1    : we_0;
        w_sel_addr  = w_sel ? addr_1  : addr_0;
        w_sel_wdata = w_sel ? wdata_1 : wdata_0;
        w_active    = w_granted && w_sel_req;
    end

    // Next-state logic: arbitration from IDLE, owner release, and burst
    // hand-over; the counter restarts whenever the grant moves or ends.
    always_comb begin
        w_state_next       = r_state;
        w_burst_cnt_next   = r_burst_cnt;
        w_last_served_next = w_active ? w_sel : r_last_served;
        case (r_state)
            IDLE: begin
                w_burst_cnt_next = 4'd0;
                if (w_pick_valid) begin
                    w_state_next = grant_of(w_pick_winner);
                end
            end
            GRANT0, GRANT1: begin
                if (!w_sel_req) begin
                    w_burst_cnt_next = 4'd0;
                    w_state_next     = w_other_req ? grant_of(~w_sel) : IDLE;
                end else if (r_burst_cnt == BURST_LAST) begin
                    // Wraps with no gap when nobody else is waiting.
                    w_burst_cnt_next = 4'd0;
                    if (w_other_req) begin
                        w_state_next = grant_of(~w_sel);
                    end
                end else begin
                    w_burst_cnt_next = r_burst_cnt + 4'd1;
                end
            end
            default: begin
                w_state_next     = IDLE;
                w_burst_cnt_next = 4'd0;
            end
        endcase
    end

    // Memory-side and requester-side outputs; everything is parked
    // (strobes inactive, buses zero) outside an ack cycle.
    always_comb begin
        ack_0        = 1'b0;
        ack_1        = 1'b0;
        rdata_0      = 8'd0;
        rdata_1      = 8'd0;
        R            = STROBE_INACTIVE;
        W            = STROBE_INACTIVE;
        mem_addr     = 8'd0;
        mem_data_out = 8'd0;
        if (w_active) begin
            mem_addr = w_sel_addr;
            if (w_sel_we) begin
                W            = STROBE_ACTIVE;
                mem_data_out = w_sel_wdata;
            end else begin
                R = STROBE_ACTIVE;
            end
            if (w_sel) begin
                ack_1   = 1'b1;
                rdata_1 = mem_in;
            end else begin
                ack_0   = 1'b1;
                rdata_0 = mem_in;
            end
        end
    end

    assign busy  = (r_state != IDLE);
    assign owner = r_last_served;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: each access pushes its expected memory
// transaction when driven; a negedge monitor pops and compares on every ack
// and checks the idle/exclusivity rules on every other cycle.
module tb_mem_arbiter;

    localparam int BMAX        = 4;
    localparam int ACK_TIMEOUT = 40;

    typedef struct packed {
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_0 = 1'b0, we_0 = 1'b0, req_1 = 1'b0, we_1 = 1'b0;
    logic [7:0] addr_0 = 8'd0, wdata_0 = 8'd0, addr_1 = 8'd0, wdata_1 = 8'd0;
    logic       ack_0, ack_1, R, W, busy, owner;
    logic [7:0] rdata_0, rdata_1, mem_addr, mem_data_out, mem_in;

    exp_t sb[$];
    int   n_checks   = 0;
    int   n_errors   = 0;
    bit   model_last = 1'b1;

    // Memory model: read data is a fixed function of the strobed address.
    assign mem_in = mem_addr ^ 8'hd3;

    always #5 clk = ~clk;

    mem_arbiter #(.BURST_MAX(BMAX)) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .ack_0(ack_0), .rdata_0(rdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .ack_1(ack_1), .rdata_1(rdata_1),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_in(mem_in),
        .R(R), .W(W), .busy(busy), .owner(owner)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-cycle monitor: scoreboard pop on ack, parked outputs otherwise.
    always @(negedge clk) begin : monitor
        exp_t e;
        check_eq("one_ack", 32'(ack_0 & ack_1), 0);
        check_eq("one_strobe", 32'(R == 1'b0 && W == 1'b0), 0);
        if (!ack_0) check_eq("rdata0_zero", 32'(rdata_0), 0);
        if (!ack_1) check_eq("rdata1_zero", 32'(rdata_1), 0);
        if (ack_0 || ack_1) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_ack", 32'({ack_1, ack_0}), 0);
            end else begin
                e = sb.pop_front();
                check_eq("ack_port", 32'(ack_1), 32'(e.port));
                check_eq("mem_addr", 32'(mem_addr), 32'(e.addr));
                check_eq("R", 32'(R), e.we ? 1 : 0);
                check_eq("W", 32'(W), e.we ? 0 : 1);
                if (e.we) check_eq("mem_data_out", 32'(mem_data_out), 32'(e.wdata));
                check_eq("rdata", 32'(e.port ? rdata_1 : rdata_0), 32'(e.addr ^ 8'hd3));
                $display("t=%0t ack%0d %s addr=%h wdata=%h rdata=%h", $time, e.port,
                         e.we ? "WR" : "RD", mem_addr, mem_data_out, e.port ? rdata_1 : rdata_0);
            end
        end else begin
            check_eq("idle_R", 32'(R), 1);
            check_eq("idle_W", 32'(W), 1);
            check_eq("idle_addr", 32'(mem_addr), 0);
            check_eq("idle_data", 32'(mem_data_out), 0);
        end
    end

    task automatic drive(input bit k, input bit rq, input bit we, input logic [7:0] a, input logic [7:0] d);
        if (k) begin
            req_1 = rq; we_1 = we; addr_1 = a; wdata_1 = d;
        end else begin
            req_0 = rq; we_0 = we; addr_0 = a; wdata_0 = d;
        end
    endtask

    task automatic expect_acc(input bit k, input bit we, input logic [7:0] a, input logic [7:0] d);
        sb.push_back('{port: k, we: we, addr: a, wdata: d});
    endtask

    // Counts posedges until requester k is acked (seen at a negedge).
    task automatic wait_ack(input bit k, output int cyc);
        cyc = 0;
        for (int i = 0; i < ACK_TIMEOUT; i++) begin
            @(negedge clk);
            if ((k ? ack_1 : ack_0) === 1'b1) return;
            cyc++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_last = 1'b1;
    endtask

    // Grant ends one cycle after the owner drops; bench sees IDLE after that.
    task automatic release_check(input string tag);
        @(negedge clk);
        check_eq({tag, "_busy_tail"}, 32'(busy), 1);
        @(negedge clk);
        check_eq({tag, "_busy_idle"}, 32'(busy), 0);
        check_eq({tag, "_owner"}, 32'(owner), 32'(model_last));
        @(posedge clk); #1;
    endtask

    task automatic single(input bit k, input bit we, input logic [7:0] a, input logic [7:0] d, input string tag);
        int cyc;
        expect_acc(k, we, a, d);
        drive(k, 1'b1, we, a, d);
        wait_ack(k, cyc);
        check_eq({tag, "_latency"}, cyc, 1);
        model_last = k;
        @(posedge clk); #1;
        drive(k, 1'b0, 1'b0, 8'd0, 8'd0);
        release_check(tag);
    endtask

    task automatic tie(input string tag);
        int cyc;
        bit first;
        first = ~model_last;
        $display("t=%0t %s: tie, requester %0d expected first", $time, tag, first);
        expect_acc(first, 1'b0, first ? 8'h31 : 8'h30, 8'd0);
        expect_acc(~first, 1'b0, first ? 8'h30 : 8'h31, 8'd0);
        drive(1'b0, 1'b1, 1'b0, 8'h30, 8'd0);
        drive(1'b1, 1'b1, 1'b0, 8'h31, 8'd0);
        wait_ack(first, cyc);
        check_eq({tag, "_first_latency"}, cyc, 1);
        @(posedge clk); #1;
        drive(first, 1'b0, 1'b0, 8'd0, 8'd0);
        wait_ack(~first, cyc);
        check_eq({tag, "_second_latency"}, cyc, 1);
        model_last = ~first;
        @(posedge clk); #1;
        drive(~first, 1'b0, 1'b0, 8'd0, 8'd0);
        release_check(tag);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_owner", 32'(owner), 1);
        check_eq("rst_R", 32'(R), 1);
        check_eq("rst_W", 32'(W), 1);
        check_eq("rst_ack", 32'({ack_1, ack_0}), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Lone read and lone write.
        single(1'b0, 1'b0, 8'h10, 8'h00, "rd0");
        single(1'b1, 1'b1, 8'hfe, 8'h5a, "wr1");

        // Ties from IDLE, round-robin via last served.
        do_reset();
        tie("tie_a");
        single(1'b0, 1'b0, 8'h44, 8'h00, "solo0");
        tie("tie_b");

        // Both held: bursts of BMAX alternate with no gap cycle.
        do_reset();
        for (int i = 0; i < 6 * BMAX; i++) begin
            if (((i / BMAX) % 2) == 0) expect_acc(1'b0, 1'b0, 8'h21, 8'h00);
            else                       expect_acc(1'b1, 1'b1, 8'h42, 8'h99);
        end
        drive(1'b0, 1'b1, 1'b0, 8'h21, 8'h00);
        drive(1'b1, 1'b1, 1'b1, 8'h42, 8'h99);
        wait_ack(1'b0, cyc);
        check_eq("burst_latency", cyc, 1);
        for (int i = 1; i < 6 * BMAX; i++) begin
            @(negedge clk);
            check_eq("burst_nogap", 32'(ack_0 | ack_1), 1);
        end
        model_last = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        release_check("burst");

        // Lone held requester: an ack every cycle past the burst limit.
        for (int i = 0; i < 3 * BMAX; i++) expect_acc(1'b1, 1'b1, 8'h5e, 8'hc7);
        drive(1'b1, 1'b1, 1'b1, 8'h5e, 8'hc7);
        wait_ack(1'b1, cyc);
        check_eq("hold_latency", cyc, 1);
        for (int i = 1; i < 3 * BMAX; i++) begin
            @(negedge clk);
            check_eq("hold_ack", 32'(ack_1), 1);
        end
        model_last = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        release_check("hold");

        // Reset aborts a write in progress; retry after release.
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 8'h77, 8'hab);
        @(posedge clk); #1;
        check_eq("abort_W_before", 32'(W), 0);
        check_eq("abort_ack_before", 32'(ack_0), 1);
        rst = 1'b1;
        #1;
        check_eq("abort_W", 32'(W), 1);
        check_eq("abort_R", 32'(R), 1);
        check_eq("abort_ack", 32'(ack_0), 0);
        check_eq("abort_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_last = 1'b1;
        check_eq("abort_release_ack", 32'(ack_0), 0);
        expect_acc(1'b0, 1'b1, 8'h77, 8'hab);
        wait_ack(1'b0, cyc);
        check_eq("abort_retry_latency", cyc, 1);
        model_last = 1'b0;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        release_check("retry");

        repeat (3) @(posedge clk);
        check_eq("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: BURST_MAX, 4, maximum consecutive accesses granted to one requester while the other is waiting (range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports, per requester k in {0,1}: req_k  input  1  access request, held until ack.
REQ-005 SHALL have ports: we_k  input  1  1 = write, 0 = read; stable while req_k high.
REQ-006 SHALL have ports: addr_k  input  8  access address; wdata_k  input  8  write data.
REQ-007 SHALL have ports: ack_k  output  1  access completed this cycle; rdata_k  output  8  read data, valid only while ack_k is high.
REQ-008 SHALL have ports: mem_addr  output  8; mem_data_out  output  8; mem_in  input  8  memory read data, combinational within the strobe cycle.
REQ-009 SHALL have ports: R  output  1  memory read strobe, active low; W  output  1  memory write strobe, active low.
REQ-010 SHALL have ports: busy  output  1  a grant is held; owner  output  1  index of the current or most recent grantee.

Function
REQ-011 SHALL implement an FSM with states IDLE, GRANT0, GRANT1, registered on posedge clk.
REQ-012 IDLE: no request -> IDLE; one request -> GRANTk for that requester; both -> GRANT of the requester not equal to last_served.
REQ-013 GRANTk: ack_k = req_k, combinational; exactly one access per ack cycle.
REQ-014 On each ack cycle: mem_addr = addr_k. For a read, R = 0 and W = 1. For a write, W = 0, R = 1, and mem_data_out = wdata_k.
REQ-015 When no grant is active, or when req_k is low in GRANTk: R = W = 1, ack = 0, and mem_addr and mem_data_out = 0.
REQ-016 rdata_k SHALL equal mem_in while ack_k is high, else 0; latency from req sampled in IDLE to first ack = 1 cycle.
REQ-017 burst_cnt (4 bits) SHALL increment on each ack and be cleared on every grant change or on entry to IDLE.
REQ-018 GRANTk transitions:
- req_k low -> GRANT of the other requester if it is requesting, else IDLE.
- req_k high, other requester waiting, and burst_cnt+1 == BURST_MAX on this ack -> other GRANT, with burst_cnt = 0.
- Otherwise remain in GRANTk.
REQ-019 With no competitor, a held req_k SHALL receive an ack every cycle indefinitely; burst_cnt wraps to 0 at BURST_MAX with no gap.
REQ-020 last_served SHALL update to k on every ack_k; ties are always resolved round-robin via last_served.
REQ-021 A grant switch SHALL insert no idle cycle: the new owner is acked in the cycle after the old owner's final ack.
REQ-022 busy = (state != IDLE); owner = last_served.
REQ-023 At most one of ack_0/ack_1 and at most one of R/W low in any cycle.

Reset
REQ-024 rst high SHALL immediately (asynchronously) force:
- state = IDLE, burst_cnt = 0, last_served = 1 (requester 0 wins the first tie);
- R = W = 1, ack_0 = ack_1 = 0, busy = 0.
REQ-025 Reset during an access SHALL abort it with no ack. A pending request SHALL be re-arbitrated from IDLE on the first posedge after rst falls.

Structure
REQ-026 A shared package arb_pkg SHALL hold: state encodings (IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2), the default BURST_MAX, and the strobe active level (0).
REQ-027 The two-way round-robin selection SHALL be a sub-module rr_pick (inputs: req_0, req_1, last_served; output: winner, valid). The rest is the FSM and muxes in mem_arbiter.

Verification
REQ-028 Reset, then req_0 read of addr 8'h10 with mem_in = 8'hc3 -> one cycle later ack_0 = 1, R = 0, mem_addr = 8'h10, rdata_0 = 8'hc3.
REQ-029 req_0 and req_1 rise together in IDLE after reset -> requester 0 acked first. Next tie from IDLE -> requester 1 acked first.
REQ-030 req_0 held continuously plus req_1 held, BURST_MAX = 4 -> ack_0 on 4 consecutive cycles, then ack_1 on 4, alternating, no gap cycle.
REQ-031 req_1 write addr 8'hfe data 8'h5a alone -> W = 0, R = 1, mem_data_out = 8'h5a for one cycle; drop req_1 -> IDLE, R = W = 1, busy = 0.
REQ-032 Assert rst mid-GRANT0 write -> W returns high in the same cycle, no ack. Release rst with req_0 still high -> ack_0 exactly one cycle after the first posedge.
REQ-033 All scenarios: assertion that ack_0 & ack_1 = 0, !(R == 0 && W == 0), and rdata_k = 0 when ack_k = 0.
